// File: rtl/haraka_ffwd_trunc.sv
// -----------------------------------------------------------------------------
// haraka_ffwd_trunc
//
// Output stage behind the Haraka-512 permutation core. Every message issued to
// the core is parked here until its permuted state comes back. The stage then
// forms the feed-forward F = perm_out ^ msg, truncates F to the 256-bit
// Haraka-512 digest and delivers it over a valid/ready interface. An in-flight
// job counter throttles msg_ready so that core results, which cannot be
// stalled, always find room in the digest FIFO.
//
// Only the four digest lanes are buffered for each message: the other 256 bits
// of F are discarded by the truncation, so they are never stored.
//
// Optional feature macro: HARAKA_FFWD_ERR_EN
//   defined   : adds err_orphan (sticky orphan flag) and orphan_cnt
//               (saturating 8-bit orphan counter) outputs
//   undefined : orphan results are dropped silently, no extra ports
//
// Ports
//   clk           in   1    clock, all logic on posedge
//   reset         in   1    synchronous, active-high; clears all state
//   msg_valid     in   1    msg issued to the permutation core this cycle
//   msg           in   512  message, same value/cycle as seen by the core
//   msg_ready     out  1    space for a new job (registered)
//   perm_valid    in   1    core presents a finished state this cycle
//   perm_out      in   512  permuted state
//   digest_valid  out  1    digest holds a result (registered)
//   digest_ready  in   1    downstream accepts digest
//   digest        out  256  truncated feed-forward result (registered)
//   err_orphan    out  1    [HARAKA_FFWD_ERR_EN] sticky orphan-result flag
//   orphan_cnt    out  8    [HARAKA_FFWD_ERR_EN] saturating orphan count
// -----------------------------------------------------------------------------
module haraka_ffwd_trunc #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [511:0] msg,
    output logic         msg_ready,
    input  logic         perm_valid,
    input  logic [511:0] perm_out,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
`ifdef HARAKA_FFWD_ERR_EN
    ,
    output logic         err_orphan,
    output logic [7:0]   orphan_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    typedef logic [PTR_W:0] ptr_t;

    localparam ptr_t ONE_C   = ptr_t'(1);
    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);

    // Message FIFO: holds only the lanes that survive truncation.
    logic [255:0] msg_mem_r [DEPTH];
    ptr_t         msg_wr_ptr_r;
    ptr_t         msg_rd_ptr_r;

    // Digest FIFO; its head is mirrored into the registered output.
    logic [255:0] dg_mem_r [DEPTH];
    ptr_t         dg_wr_ptr_r;
    ptr_t         dg_rd_ptr_r;

    ptr_t         inflight_r;
    logic         msg_ready_r;
    logic         digest_valid_r;
    logic [255:0] digest_r;

    logic         accept_s;
    logic         msg_empty_s;
    logic         retire_s;
    logic         pop_s;
    logic [255:0] msg_trunc_s;
    logic [255:0] perm_trunc_s;
    logic [255:0] retire_digest_s;
    ptr_t         dg_rd_next_s;
    ptr_t         dg_wr_next_s;
    logic         dg_empty_next_s;
    logic [255:0] head_next_s;
    ptr_t         inflight_next_s;

    // Lanes of F dropped by the truncation never reach any logic.
    logic msg_unused_s;
    logic perm_unused_s;

    assign msg_unused_s  = ^{msg[511:448], msg[383:320], msg[191:128], msg[63:0]};
    assign perm_unused_s = ^{perm_out[511:448], perm_out[383:320],
                             perm_out[191:128], perm_out[63:0]};

    // Truncation commutes with XOR, so truncate each operand first.
    assign msg_trunc_s  = {msg[447:384], msg[319:256], msg[255:192], msg[127:64]};
    assign perm_trunc_s = {perm_out[447:384], perm_out[319:256],
                           perm_out[255:192], perm_out[127:64]};

    assign accept_s        = msg_valid & msg_ready_r;
    assign msg_empty_s     = (msg_wr_ptr_r == msg_rd_ptr_r);
    assign retire_s        = perm_valid & ~msg_empty_s;
    assign pop_s           = digest_valid_r & digest_ready;
    assign retire_digest_s = perm_trunc_s ^ msg_mem_r[msg_rd_ptr_r[PTR_W-1:0]];

    assign dg_rd_next_s    = pop_s    ? (dg_rd_ptr_r + ONE_C) : dg_rd_ptr_r;
    assign dg_wr_next_s    = retire_s ? (dg_wr_ptr_r + ONE_C) : dg_wr_ptr_r;
    assign dg_empty_next_s = (dg_rd_next_s == dg_wr_next_s);

    // Next head of the digest FIFO: bypass the retiring digest when it lands
    // in an otherwise empty FIFO, giving one-cycle perm_valid -> digest_valid.
    always_comb begin
        head_next_s = dg_mem_r[dg_rd_next_s[PTR_W-1:0]];
        if (retire_s && (dg_rd_next_s == dg_wr_ptr_r)) begin
            head_next_s = retire_digest_s;
        end else begin
            head_next_s = dg_mem_r[dg_rd_next_s[PTR_W-1:0]];
        end
    end

    // Next in-flight count: accepts add, digest handshakes retire a job.
    always_comb begin
        inflight_next_s = inflight_r;
        case ({accept_s, pop_s})
            2'b10:   inflight_next_s = inflight_r + ONE_C;
            2'b01:   inflight_next_s = inflight_r - ONE_C;
            default: inflight_next_s = inflight_r;
        endcase
    end

    // FIFO storage writes; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            msg_mem_r[msg_wr_ptr_r[PTR_W-1:0]] <= msg_trunc_s;
        end
        if (retire_s) begin
            dg_mem_r[dg_wr_ptr_r[PTR_W-1:0]] <= retire_digest_s;
        end
    end

    // Pointer, in-flight count and msg_ready bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_wr_ptr_r <= '0;
            msg_rd_ptr_r <= '0;
            dg_wr_ptr_r  <= '0;
            dg_rd_ptr_r  <= '0;
            inflight_r   <= '0;
            msg_ready_r  <= 1'b0;
        end else begin
            msg_wr_ptr_r <= accept_s ? (msg_wr_ptr_r + ONE_C) : msg_wr_ptr_r;
            msg_rd_ptr_r <= retire_s ? (msg_rd_ptr_r + ONE_C) : msg_rd_ptr_r;
            dg_wr_ptr_r  <= dg_wr_next_s;
            dg_rd_ptr_r  <= dg_rd_next_s;
            inflight_r   <= inflight_next_s;
            msg_ready_r  <= (inflight_next_s < DEPTH_C);
        end
    end

    // Registered show-ahead output; digest holds its last value when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            digest_valid_r <= 1'b0;
            digest_r       <= 256'd0;
        end else begin
            digest_valid_r <= ~dg_empty_next_s;
            if (!dg_empty_next_s) begin
                digest_r <= head_next_s;
            end else begin
                digest_r <= digest_r;
            end
        end
    end

    assign msg_ready    = msg_ready_r;
    assign digest_valid = digest_valid_r;
    assign digest       = digest_r;

`ifdef HARAKA_FFWD_ERR_EN
    logic       orphan_s;
    logic       err_orphan_r;
    logic [7:0] orphan_cnt_r;

    // A result with no parked message is an orphan (e.g. job predates reset).
    assign orphan_s = perm_valid & msg_empty_s;

    // Sticky orphan flag and saturating orphan counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_orphan_r <= 1'b0;
            orphan_cnt_r <= 8'd0;
        end else if (orphan_s) begin
            err_orphan_r <= 1'b1;
            orphan_cnt_r <= (orphan_cnt_r != 8'hFF) ? (orphan_cnt_r + 8'd1) : orphan_cnt_r;
        end else begin
            err_orphan_r <= err_orphan_r;
            orphan_cnt_r <= orphan_cnt_r;
        end
    end

    assign err_orphan = err_orphan_r;
    assign orphan_cnt = orphan_cnt_r;
`endif

endmodule

// File: tb/tb_haraka_ffwd_trunc.sv
module tb_haraka_ffwd_trunc;

    logic         clk;
    logic         reset;
    logic         msg_valid;
    logic [511:0] msg;
    logic         msg_ready;
    logic         perm_valid;
    logic [511:0] perm_out;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest;
`ifdef HARAKA_FFWD_ERR_EN
    logic         err_orphan;
    logic [7:0]   orphan_cnt;
`endif

    haraka_ffwd_trunc #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .msg_valid    (msg_valid),
        .msg          (msg),
        .msg_ready    (msg_ready),
        .perm_valid   (perm_valid),
        .perm_out     (perm_out),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest)
`ifdef HARAKA_FFWD_ERR_EN
        ,
        .err_orphan   (err_orphan),
        .orphan_cnt   (orphan_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] msg;
        logic [511:0] perm;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        msg_valid    = 1'b0;
        perm_valid   = 1'b0;
        msg          = '0;
        perm_out     = '0;
        digest_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Message whose eight words all equal (j+1)*0x0101..01; with perm_out=0
    // its digest is that word repeated four times.
    function automatic logic [63:0] word_of(input int j);
        return 64'(j + 1) * 64'h0101010101010101;
    endfunction

    function automatic logic [511:0] mk_msg(input int j);
        return {8{word_of(j)}};
    endfunction

    function automatic logic [255:0] mk_dig(input int j);
        return {4{word_of(j)}};
    endfunction

    // Reference truncation: lanes 1,3,4,6 (64-bit words) of F, low lane first.
    function automatic logic [255:0] model_trunc(input logic [511:0] f);
        return {f[447:384], f[319:256], f[255:192], f[127:64]};
    endfunction

    initial begin
        logic [511:0] tmp;
        logic [511:0] msg_q [$];
        logic [255:0] exp_q [$];
        int           issued;
        int           got;
        int           w;
        logic         mv, pv, dr, acc, pop;
        logic [511:0] m, p;

        // Directed vectors with hand-computed digests.
        tmp = '0;
        for (int i = 0; i < 8; i++) tmp[64*i +: 64] = 64'(i);
        vecs[0].msg  = '0;
        vecs[0].perm = tmp;
        vecs[0].exp  = {64'd6, 64'd4, 64'd3, 64'd1};
        vecs[1].msg  = {64{8'hA5}};
        vecs[1].perm = {64{8'hA5}};
        vecs[1].exp  = 256'd0;
        vecs[2].msg  = {64{8'hFF}};
        vecs[2].perm = 512'd0;
        vecs[2].exp  = {32{8'hFF}};
        vecs[3].msg  = {8{64'hFFFF0000FFFF0000}};
        vecs[3].perm = {8{64'h0F0F0F0F0F0F0F0F}};
        vecs[3].exp  = {4{64'hF0F00F0FF0F00F0F}};
        // perm has ones only in dropped words 0,2,5,7; msg only in kept words.
        vecs[4].msg  = {64'h0, 64'hAAAAAAAAAAAAAAAA, 64'h0, 64'h4444444444444444,
                        64'h3333333333333333, 64'h0, 64'h1111111111111111, 64'h0};
        vecs[4].perm = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                        64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF};
        vecs[4].exp  = {64'hAAAAAAAAAAAAAAAA, 64'h4444444444444444,
                        64'h3333333333333333, 64'h1111111111111111};

        // Reset state.
        reset        = 1'b1;
        msg_valid    = 1'b0;
        perm_valid   = 1'b0;
        msg          = '0;
        perm_out     = '0;
        digest_ready = 1'b0;
        step();
        check("rst_msg_ready", msg_ready, 0);
        check("rst_digest_valid", digest_valid, 0);
        check("rst_digest", digest, 0);
        reset = 1'b0;
        step();
        check("post_rst_msg_ready", msg_ready, 1);

        // Table-driven single jobs with digest_ready high.
        digest_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = 0;
            while (!msg_ready && w < 20) begin step(); w++; end
            check("vec_msg_ready", msg_ready, 1);
            msg_valid = 1'b1;
            msg       = vecs[i].msg;
            step();
            msg_valid  = 1'b0;
            perm_valid = 1'b1;
            perm_out   = vecs[i].perm;
            check("vec_idle_valid", digest_valid, 0);
            step();
            perm_valid = 1'b0;
            check("vec_latency_valid", digest_valid, 1);
            check("vec_digest", digest, vecs[i].exp);
            step();
            check("vec_popped", digest_valid, 0);
        end

        // Backpressure: four jobs fill the stage, digests held then drained in order.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            msg_valid = 1'b1;
            msg       = mk_msg(j);
            step();
        end
        msg = mk_msg(9);
        check("bp_full_ready", msg_ready, 0);
        for (int j = 0; j < 4; j++) begin
            perm_valid = 1'b1;
            perm_out   = '0;
            step();
            perm_valid = 1'b0;
            check("bp_hold_valid", digest_valid, 1);
            check("bp_hold_digest", digest, mk_dig(0));
        end
        step();
        check("bp_stable_digest", digest, mk_dig(0));
        check("bp_still_full", msg_ready, 0);
        digest_ready = 1'b1;
        step();
        msg_valid = 1'b0;
        check("bp_ready_after_pop", msg_ready, 1);
        for (int j = 1; j < 4; j++) begin
            check("bp_order_valid", digest_valid, 1);
            check("bp_order_digest", digest, mk_dig(j));
            step();
        end
        check("bp_drained", digest_valid, 0);

        // Same-cycle accept and pop at inflight=3 keeps the count at 3.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            msg_valid = 1'b1;
            msg       = mk_msg(j);
            step();
        end
        msg_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            perm_valid = 1'b1;
            perm_out   = '0;
            step();
        end
        perm_valid = 1'b0;
        check("ap_head", digest, mk_dig(0));
        check("ap_ready3", msg_ready, 1);
        msg_valid    = 1'b1;
        msg          = mk_msg(3);
        digest_ready = 1'b1;
        step();
        check("ap_ready_after_swap", msg_ready, 1);
        digest_ready = 1'b0;
        msg          = mk_msg(4);
        step();
        msg_valid = 1'b0;
        check("ap_full_after_accept", msg_ready, 0);
        for (int j = 0; j < 2; j++) begin
            perm_valid = 1'b1;
            perm_out   = '0;
            step();
        end
        perm_valid   = 1'b0;
        digest_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            check("ap_order_valid", digest_valid, 1);
            check("ap_order_digest", digest, mk_dig(j));
            step();
        end
        check("ap_drained", digest_valid, 0);
        check("ap_ready_end", msg_ready, 1);

        // Reset mid-operation: late core results are orphans.
        do_reset();
`ifdef HARAKA_FFWD_ERR_EN
        check("orph_flag_clear", err_orphan, 0);
`endif
        digest_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            msg_valid = 1'b1;
            msg       = mk_msg(j);
            step();
        end
        msg_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            perm_valid = 1'b1;
            perm_out   = '0;
            step();
            check("orph_no_valid", digest_valid, 0);
        end
        perm_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("orph_quiet", digest_valid, 0);
            step();
        end
`ifdef HARAKA_FFWD_ERR_EN
        check("orph_flag", err_orphan, 1);
        check("orph_cnt", orphan_cnt, 2);
`endif
        // Orphan result coinciding with a new accept: message still enqueued.
        msg_valid  = 1'b1;
        msg        = mk_msg(5);
        perm_valid = 1'b1;
        perm_out   = '0;
        step();
        msg_valid = 1'b0;
        check("orph_cc_no_valid", digest_valid, 0);
        step();
        perm_valid = 1'b0;
        check("orph_cc_valid", digest_valid, 1);
        check("orph_cc_digest", digest, mk_dig(5));
`ifdef HARAKA_FFWD_ERR_EN
        check("orph_cc_cnt", orphan_cnt, 3);
`endif

        // Pointer wrap: 3*DEPTH+1 random jobs with random stalls vs scoreboard.
        do_reset();
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 3000 && got < 13; cyc++) begin
            mv = (issued < 13) && ($urandom_range(0, 3) != 0);
            pv = (msg_q.size() > 0) && ($urandom_range(0, 2) != 0);
            dr = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 16; k++) begin
                m[32*k +: 32] = $urandom;
                p[32*k +: 32] = $urandom;
            end
            msg_valid    = mv;
            msg          = m;
            perm_valid   = pv;
            perm_out     = p;
            digest_ready = dr;
            acc = mv && msg_ready;
            pop = digest_valid && dr;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("wrap_extra_digest", 1, 0);
                end else begin
                    check("wrap_digest", digest, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got++;
            end
            step();
            if (pv) begin
                exp_q.push_back(model_trunc(p ^ msg_q[0]));
                void'(msg_q.pop_front());
            end
            if (acc) begin
                msg_q.push_back(m);
                issued++;
            end
        end
        msg_valid    = 1'b0;
        perm_valid   = 1'b0;
        digest_ready = 1'b0;
        check("wrap_count", 256'(got), 256'd13);
        step();
        check("wrap_empty", digest_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
